iob_cache_fe_arb: RTL and testbench

IOB_CACHE_FE_ARB -- requirements
Module: iob_cache_fe_arb

---
 rtl/iob_cache_fe_arb_pkg.sv | 18 +
 rtl/iob_cache_rr_arbiter.sv | 32 +++
 rtl/iob_cache_fe_arb.sv | 116 +++++++++++
 tb/tb_iob_cache_fe_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_fe_arb_pkg.sv
// rtl/iob_cache_fe_arb_pkg.sv - shared state encodings and helpers for the front-end arbiter
package iob_cache_fe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Ceiling log2 that never returns less than 1, so a single-port build still has a grant index bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iob_cache_rr_arbiter.sv
// rtl/iob_cache_rr_arbiter.sv - combinational round-robin / fixed-priority grant selection
module iob_cache_rr_arbiter
  import iob_cache_fe_arb_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic [N_PORTS-1:0]                req,
  input  logic [clog2_min1(N_PORTS)-1:0]    ptr,
  output logic [clog2_min1(N_PORTS)-1:0]    gnt_idx,
  output logic                              gnt_vld
);

  localparam int GID_W = clog2_min1(N_PORTS);

  int idx;

  // Scan from the pointer (or from 0 in fixed priority), wrapping past the top index
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (PRIO_MODE == 1) ? i : (int'(ptr) + i) % N_PORTS;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = GID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iob_cache_fe_arb.sv
// rtl/iob_cache_fe_arb.sv - N-port IOb front-end arbiter funnelling requests into one cache port
module iob_cache_fe_arb
  import iob_cache_fe_arb_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0]                req,
  input  logic [N_PORTS*ADDR_W-1:0]         addr,
  input  logic [N_PORTS*DATA_W-1:0]         wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0]     wstrb,
  output logic [N_PORTS*DATA_W-1:0]         rdata,
  output logic [N_PORTS-1:0]                ack,
  output logic                              m_req,
  output logic [ADDR_W-1:0]                 m_addr,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  input  logic [DATA_W-1:0]                 m_rdata,
  input  logic                              m_ack,
  output logic [clog2_min1(N_PORTS)-1:0]    grant_id
);

  localparam int NBYTES = DATA_W / 8;
  localparam int GID_W  = clog2_min1(N_PORTS);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NBYTES-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic [GID_W-1:0]  gid_q;
  logic [GID_W-1:0]  ptr_q;
  logic [GID_W-1:0]  ptr_nxt;
  logic [GID_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              load;
  logic              capture;

  generate
    if (N_PORTS == 1) begin : g_single
      assign gnt_vld = req[0];
      assign gnt_idx = '0;
    end else begin : g_multi
      iob_cache_rr_arbiter #(
        .N_PORTS   (N_PORTS),
        .PRIO_MODE (PRIO_MODE)
      ) u_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
      );
    end
  endgenerate

  assign ptr_nxt = (gnt_idx == GID_W'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE, ACK: begin
        if (gnt_vld) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (m_ack) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        addr_q  <= addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        wdata_q <= wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        wstrb_q <= wstrb[int'(gnt_idx)*NBYTES +: NBYTES];
        gid_q   <= gnt_idx;
        if (PRIO_MODE == 0) ptr_q <= ptr_nxt;
      end
      if (capture) rdata_q <= m_rdata;
    end
  end

  // Downstream fields come only from the registers, so requester changes during BUSY are invisible
  assign m_req    = (state == BUSY);
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign grant_id = gid_q;
  assign rdata    = {N_PORTS{rdata_q}};
  assign ack      = (state == ACK) ? (N_PORTS'(1) << gid_q) : '0;

endmodule

// File: tb/tb_iob_cache_fe_arb.sv
// tb/tb_iob_cache_fe_arb.sv - directed self-checking bench for iob_cache_fe_arb
module tb_iob_cache_fe_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Two-port round-robin instance
  logic [1:0]  req2;
  logic [59:0] addr2;
  logic [63:0] wdata2;
  logic [7:0]  wstrb2;
  logic [63:0] rdata2;
  logic [1:0]  ack2;
  logic        m_req2;
  logic [29:0] m_addr2;
  logic [31:0] m_wdata2;
  logic [3:0]  m_wstrb2;
  logic [31:0] m_rdata2;
  logic        m_ack2;
  logic [0:0]  gid2;

  // Four-port round-robin instance
  logic [3:0]   req4;
  logic [119:0] addr4;
  logic [127:0] wdata4;
  logic [15:0]  wstrb4;
  logic [127:0] rdata4;
  logic [3:0]   ack4;
  logic         m_req4;
  logic [29:0]  m_addr4;
  logic [31:0]  m_wdata4;
  logic [3:0]   m_wstrb4;
  logic [31:0]  m_rdata4;
  logic         m_ack4;
  logic [1:0]   gid4;

  // Four-port fixed-priority instance
  logic [3:0]   req4p;
  logic [119:0] addr4p;
  logic [127:0] wdata4p;
  logic [15:0]  wstrb4p;
  logic [127:0] rdata4p;
  logic [3:0]   ack4p;
  logic         m_req4p;
  logic [29:0]  m_addr4p;
  logic [31:0]  m_wdata4p;
  logic [3:0]   m_wstrb4p;
  logic [31:0]  m_rdata4p;
  logic         m_ack4p;
  logic [1:0]   gid4p;

  // Single-port instance
  logic [0:0]  req1;
  logic [29:0] addr1;
  logic [31:0] wdata1;
  logic [3:0]  wstrb1;
  logic [31:0] rdata1;
  logic [0:0]  ack1;
  logic        m_req1;
  logic [29:0] m_addr1;
  logic [31:0] m_wdata1;
  logic [3:0]  m_wstrb1;
  logic [31:0] m_rdata1;
  logic        m_ack1;
  logic [0:0]  gid1;

  iob_cache_fe_arb #(.N_PORTS(2), .PRIO_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .addr(addr2), .wdata(wdata2), .wstrb(wstrb2),
    .rdata(rdata2), .ack(ack2), .m_req(m_req2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_wstrb(m_wstrb2), .m_rdata(m_rdata2), .m_ack(m_ack2), .grant_id(gid2)
  );

  iob_cache_fe_arb #(.N_PORTS(4), .PRIO_MODE(0)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .addr(addr4), .wdata(wdata4), .wstrb(wstrb4),
    .rdata(rdata4), .ack(ack4), .m_req(m_req4), .m_addr(m_addr4), .m_wdata(m_wdata4),
    .m_wstrb(m_wstrb4), .m_rdata(m_rdata4), .m_ack(m_ack4), .grant_id(gid4)
  );

  iob_cache_fe_arb #(.N_PORTS(4), .PRIO_MODE(1)) u_dut4p (
    .clk(clk), .rst(rst), .req(req4p), .addr(addr4p), .wdata(wdata4p), .wstrb(wstrb4p),
    .rdata(rdata4p), .ack(ack4p), .m_req(m_req4p), .m_addr(m_addr4p), .m_wdata(m_wdata4p),
    .m_wstrb(m_wstrb4p), .m_rdata(m_rdata4p), .m_ack(m_ack4p), .grant_id(gid4p)
  );

  iob_cache_fe_arb #(.N_PORTS(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .wdata(wdata1), .wstrb(wstrb1),
    .rdata(rdata1), .ack(ack1), .m_req(m_req1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_wstrb(m_wstrb1), .m_rdata(m_rdata1), .m_ack(m_ack1), .grant_id(gid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({m_req2, ack2, rdata2, gid2, m_addr2, m_wdata2, m_wstrb2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got m_req=%b ack=%b rdata=%h gid=%0d m_addr=%h, required all zero",
               m_req2, ack2, rdata2, gid2, m_addr2);
    end
    n_checks++;
    if ({m_req4, ack4, gid4, m_req4p, ack4p, gid4p, m_req1, ack1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut4: got m_req4=%b ack4=%b gid4=%0d m_req4p=%b ack4p=%b, required zero",
               m_req4, ack4, gid4, m_req4p, ack4p);
    end
    // Single-port requester waits in reset so the first post-release edge must grant it
    req1  = 1'b1;
    addr1 = 30'h3FF;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (m_req1 !== 1'b1 || m_addr1 !== 30'h3FF || gid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_arb_single: got m_req=%b m_addr=%h gid=%0d, required 1 3ff 0",
               m_req1, m_addr1, gid1);
    end
  endtask

  task automatic test_single_port();
    m_ack1   = 1'b1;
    m_rdata1 = 32'hA5A5A5A5;
    tick();
    n_checks++;
    if (ack1 !== 1'b1 || rdata1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL single_port_ack: got ack=%b rdata=%h, required 1 a5a5a5a5", ack1, rdata1);
    end
    req1   = 1'b0;
    m_ack1 = 1'b0;
    tick();
    n_checks++;
    if (ack1 !== 1'b0 || m_req1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_port_idle: got ack=%b m_req=%b, required 0 0", ack1, m_req1);
    end
  endtask

  task automatic test_single_read();
    req2          = 2'b10;
    addr2[59:30]  = 30'h100;
    wstrb2        = 8'h00;
    tick();
    n_checks++;
    if (m_req2 !== 1'b1 || m_addr2 !== 30'h100 || gid2 !== 1'b1 || m_wstrb2 !== 4'h0) begin
      n_fail++;
      $display("FAIL read_busy: got m_req=%b m_addr=%h gid=%0d wstrb=%h, required 1 100 1 0",
               m_req2, m_addr2, gid2, m_wstrb2);
    end
    m_ack2   = 1'b1;
    m_rdata2 = 32'hDEADBEEF;
    tick();
    n_checks++;
    if (ack2 !== 2'b10 || rdata2 !== {2{32'hDEADBEEF}} || m_req2 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_ack: got ack=%b rdata=%h m_req=%b, required 10 deadbeefdeadbeef 0",
               ack2, rdata2, m_req2);
    end
    req2   = 2'b00;
    m_ack2 = 1'b0;
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || m_req2 !== 1'b0 || rdata2 !== {2{32'hDEADBEEF}}) begin
      n_fail++;
      $display("FAIL read_idle: got ack=%b m_req=%b rdata=%h, required 00 0 rdata held",
               ack2, m_req2, rdata2);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    req4   = 4'hF;
    m_ack4 = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_g = 2'(g % 4);
      tick();
      n_checks++;
      if (m_req4 !== 1'b1 || gid4 !== exp_g || ack4 !== 4'h0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got m_req=%b gid=%0d ack=%b, required 1 %0d 0000",
                 g, m_req4, gid4, ack4, exp_g);
      end
      tick();
      n_checks++;
      if (ack4 !== (4'b0001 << exp_g)) begin
        n_fail++;
        $display("FAIL rr_ack%0d: got ack=%b, required %b", g, ack4, 4'b0001 << exp_g);
      end
    end
    req4   = 4'h0;
    m_ack4 = 1'b0;
    tick();
    n_checks++;
    if (ack4 !== 4'h0 || m_req4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: got ack=%b m_req=%b, required 0000 0", ack4, m_req4);
    end
    // Pointer now sits at 1, so an all-request burst must go to port 1
    req4 = 4'hF;
    tick();
    n_checks++;
    if (gid4 !== 2'd1 || m_req4 !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_ptr_start: got gid=%0d m_req=%b, required 1 1", gid4, m_req4);
    end
    m_ack4 = 1'b1;
    req4   = 4'h0;
    tick();
    m_ack4 = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority();
    req4p   = 4'b1010;
    m_ack4p = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_checks++;
      if (m_req4p !== 1'b1 || gid4p !== 2'd1) begin
        n_fail++;
        $display("FAIL prio_grant%0d: got m_req=%b gid=%0d, required 1 1", g, m_req4p, gid4p);
      end
      tick();
      n_checks++;
      if (ack4p !== 4'b0010) begin
        n_fail++;
        $display("FAIL prio_ack%0d: got ack=%b, required 0010", g, ack4p);
      end
    end
    req4p = 4'b1000;
    tick();
    n_checks++;
    if (m_req4p !== 1'b1 || gid4p !== 2'd3) begin
      n_fail++;
      $display("FAIL prio_port3: got m_req=%b gid=%0d, required 1 3", m_req4p, gid4p);
    end
    tick();
    n_checks++;
    if (ack4p !== 4'b1000) begin
      n_fail++;
      $display("FAIL prio_port3_ack: got ack=%b, required 1000", ack4p);
    end
    req4p   = 4'h0;
    m_ack4p = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req2         = 2'b01;
    addr2[29:0]  = 30'h55;
    wstrb2       = 8'h00;
    tick();
    m_ack2   = 1'b1;
    m_rdata2 = 32'h11111111;
    tick();
    n_checks++;
    if (ack2 !== 2'b01 || rdata2 !== {2{32'h11111111}}) begin
      n_fail++;
      $display("FAIL b2b_first_ack: got ack=%b rdata=%h, required 01 1111111111111111", ack2, rdata2);
    end
    wstrb2[3:0]  = 4'hF;
    wdata2[31:0] = 32'h12345678;
    m_ack2       = 1'b0;
    tick();
    n_checks++;
    if (m_req2 !== 1'b1 || m_wstrb2 !== 4'hF || m_wdata2 !== 32'h12345678 ||
        ack2 !== 2'b00 || gid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_busy: got m_req=%b wstrb=%h wdata=%h ack=%b gid=%0d, required 1 f 12345678 00 0",
               m_req2, m_wstrb2, m_wdata2, ack2, gid2);
    end
    m_ack2 = 1'b1;
    tick();
    n_checks++;
    if (ack2 !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_second_ack: got ack=%b, required 01", ack2);
    end
    req2   = 2'b00;
    m_ack2 = 1'b0;
    wstrb2 = 8'h00;
    tick();
  endtask

  task automatic test_stall();
    logic [67:0] exp_bus;
    req2          = 2'b10;
    addr2[59:30]  = 30'h2AA;
    wdata2[63:32] = 32'hCAFEF00D;
    wstrb2[7:4]   = 4'h3;
    m_rdata2      = 32'h0BADF00D;
    tick();
    exp_bus = {1'b1, 30'h2AA, 32'hCAFEF00D, 4'h3, 1'b1};
    // Scramble the granted port's fields and add a competing request during the stall
    req2          = 2'b11;
    addr2[59:30]  = 30'h0;
    wdata2[63:32] = 32'h0;
    wstrb2[7:4]   = 4'hF;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({m_req2, m_addr2, m_wdata2, m_wstrb2, gid2} !== exp_bus || ack2 !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got req/addr/wdata/wstrb/gid=%h ack=%b, required %h 00",
                 c, {m_req2, m_addr2, m_wdata2, m_wstrb2, gid2}, ack2, exp_bus);
      end
      tick();
    end
    m_ack2 = 1'b1;
    req2   = 2'b00;
    tick();
    n_checks++;
    if (ack2 !== 2'b10 || rdata2 !== {2{32'h0BADF00D}}) begin
      n_fail++;
      $display("FAIL stall_ack: got ack=%b rdata=%h, required 10 0badf00d0badf00d", ack2, rdata2);
    end
    m_ack2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    req2        = 2'b01;
    addr2[29:0] = 30'h77;
    tick();
    n_checks++;
    if (m_req2 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: got m_req=%b, required 1", m_req2);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_req2 !== 1'b0 || rdata2 !== 64'h0 || m_addr2 !== 30'h0 || gid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got m_req=%b rdata=%h m_addr=%h gid=%0d, required all zero",
               m_req2, rdata2, m_addr2, gid2);
    end
    req2 = 2'b00;
    tick();
    rst    = 1'b1;
    m_ack2 = 1'b1;
    tick();
    m_ack2 = 1'b0;
    n_checks++;
    if (ack2 !== 2'b00 || m_req2 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_ack: got ack=%b m_req=%b, required 00 0", ack2, m_req2);
    end
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || m_req2 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got ack=%b m_req=%b, required 00 0", ack2, m_req2);
    end
  endtask

  initial begin
    req2 = '0;  addr2 = '0;  wdata2 = '0;  wstrb2 = '0;  m_rdata2 = '0;  m_ack2 = 1'b0;
    req4 = '0;  addr4 = '0;  wdata4 = '0;  wstrb4 = '0;  m_rdata4 = '0;  m_ack4 = 1'b0;
    req4p = '0; addr4p = '0; wdata4p = '0; wstrb4p = '0; m_rdata4p = '0; m_ack4p = 1'b0;
    req1 = '0;  addr1 = '0;  wdata1 = '0;  wstrb1 = '0;  m_rdata1 = '0;  m_ack1 = 1'b0;
    test_reset();
    test_single_port();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
